// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32 core: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_EN.
module multicycle_control #(
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [1:0]          alu_op_main,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                pc_src,
  output logic                instr_done,
  output logic                illegal,
  output logic [31:0]         instret
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ILLEGAL   = 4'd10
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);

  state_t              state_r;
  state_t              state_next_s;
  logic [OPCODE_W-1:0] opcode_r;

  logic [1:0] alu_op_main_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic       mem_to_reg_s;
  logic       pc_src_s;
  logic       instr_done_s;
  logic       illegal_s;

  // State register and opcode latch; MEM_ADDR relies on the latched copy, not on IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_FETCH;
      opcode_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_DECODE) begin
        opcode_r <= opcode;
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next_s  = state_r;
    alu_op_main_s = 2'b00;
    alu_src_a_s   = 2'b00;
    alu_src_b_s   = 2'b00;
    iord_s        = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    mem_to_reg_s  = 1'b0;
    pc_src_s      = 1'b0;
    instr_done_s  = 1'b0;
    illegal_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        if (mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_next_s = S_MEM_ADDR;
          OP_RTYPE:          state_next_s = S_EXEC_R;
          OP_ITYPE:          state_next_s = S_EXEC_I;
          OP_BRANCH:         state_next_s = S_BRANCH;
          default:           state_next_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b10;
        if (opcode_r == OP_LOAD) begin
          state_next_s = S_MEM_READ;
        end else begin
          state_next_s = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (mem_ready) begin
          state_next_s = S_MEM_WB;
        end else begin
          state_next_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (mem_ready) begin
          instr_done_s = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_WRITE;
        end
      end
      S_EXEC_R: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b00;
        alu_op_main_s = 2'b10;
        state_next_s  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b10;
        alu_op_main_s = 2'b10;
        state_next_s  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b00;
        alu_op_main_s = 2'b01;
        pc_src_s      = 1'b1;
        pc_write_s    = zero;
        instr_done_s  = 1'b1;
        state_next_s  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_s    = 1'b1;
        state_next_s = S_FETCH;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // Reset masks every output, so no strobe escapes while rst is high.
  assign alu_op_main = rst ? 2'b00 : alu_op_main_s;
  assign alu_src_a   = rst ? 2'b00 : alu_src_a_s;
  assign alu_src_b   = rst ? 2'b00 : alu_src_b_s;
  assign iord        = rst ? 1'b0 : iord_s;
  assign mem_read    = rst ? 1'b0 : mem_read_s;
  assign mem_write   = rst ? 1'b0 : mem_write_s;
  assign ir_write    = rst ? 1'b0 : ir_write_s;
  assign pc_write    = rst ? 1'b0 : pc_write_s;
  assign reg_write   = rst ? 1'b0 : reg_write_s;
  assign mem_to_reg  = rst ? 1'b0 : mem_to_reg_s;
  assign pc_src      = rst ? 1'b0 : pc_src_s;
  assign instr_done  = rst ? 1'b0 : instr_done_s;
  assign illegal     = rst ? 1'b0 : illegal_s;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret_r;

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= 32'd0;
    end else if (instr_done_s) begin
      instret_r <= instret_r + 32'd1;
    end
  end

  assign instret = rst ? 32'd0 : instret_r;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors plus a retirement scoreboard.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  alu_op_main;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_src;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instret;

  multicycle_control #(.OPCODE_W(7)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op_main(alu_op_main), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {alu_op_main, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
  //  pc_write, reg_write, mem_to_reg, pc_src, instr_done, illegal}
  logic [15:0] outv;
  assign outv = {alu_op_main, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                 pc_write, reg_write, mem_to_reg, pc_src, instr_done, illegal};

  localparam logic [15:0] V_ZERO  = 16'h0000;
  localparam logic [15:0] F_RDY   = {2'b00, 2'b00, 2'b01, 10'b0101100000};
  localparam logic [15:0] F_WAIT  = {2'b00, 2'b00, 2'b01, 10'b0100000000};
  localparam logic [15:0] DEC     = {2'b00, 2'b01, 2'b10, 10'b0000000000};
  localparam logic [15:0] MADDR   = {2'b00, 2'b10, 2'b10, 10'b0000000000};
  localparam logic [15:0] MRD     = {2'b00, 2'b00, 2'b00, 10'b1100000000};
  localparam logic [15:0] MWB     = {2'b00, 2'b00, 2'b00, 10'b0000011010};
  localparam logic [15:0] MWR_RDY = {2'b00, 2'b00, 2'b00, 10'b1010000010};
  localparam logic [15:0] MWR_W   = {2'b00, 2'b00, 2'b00, 10'b1010000000};
  localparam logic [15:0] EXR     = {2'b10, 2'b10, 2'b00, 10'b0000000000};
  localparam logic [15:0] EXI     = {2'b10, 2'b10, 2'b10, 10'b0000000000};
  localparam logic [15:0] ALUWB   = {2'b00, 2'b00, 2'b00, 10'b0000010010};
  localparam logic [15:0] BR_Z1   = {2'b01, 2'b10, 2'b00, 10'b0000100110};
  localparam logic [15:0] BR_Z0   = {2'b01, 2'b10, 2'b00, 10'b0000000110};
  localparam logic [15:0] ILL     = {2'b00, 2'b00, 2'b00, 10'b0000000001};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic ill;
    logic [31:0] lat;
  } sb_t;

  sb_t         sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret  = 32'd0;
  int          lat_cnt  = 0;

  task automatic push(input logic ill, input int lat);
    sb_t e;
    e.ill = ill;
    e.lat = 32'(lat);
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs and compare the full output vector and instret at the falling edge.
  task automatic cyc(input logic mr, input logic z, input logic [6:0] op,
                     input logic [15:0] exp, input string nm);
    logic [31:0] er;
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    @(negedge clk);
    n_checks++;
    if (outv !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %h expected %h", nm, outv, exp);
    end
`ifdef MC_CTRL_PERF_EN
    er = exp_ret;
`else
    er = 32'd0;
`endif
    n_checks++;
    if (instret !== er) begin
      n_fail++;
      $display("FAIL %s_instret: got %h expected %h", nm, instret, er);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each retire/illegal pulse pop the scoreboard and check kind and latency.
  always @(negedge clk) begin
    if (rst) begin
      lat_cnt = 0;
    end else begin
      lat_cnt++;
      if (instr_done || illegal) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got done=%0b illegal=%0b expected no event", instr_done, illegal);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          if ({instr_done, illegal} !== {~e.ill, e.ill} || 32'(lat_cnt) !== e.lat) begin
            n_fail++;
            $display("FAIL sb_event: got done=%0b illegal=%0b lat=%0d expected done=%0b illegal=%0b lat=%0d",
                     instr_done, illegal, lat_cnt, ~e.ill, e.ill, e.lat);
          end
        end
        lat_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
    cyc(1'b1, 1'b0, OP_R, V_ZERO, "reset0");
    cyc(1'b1, 1'b0, OP_R, V_ZERO, "reset1");
    rst = 1'b0;

    // ADD, zero wait
    push(1'b0, 4);
    cyc(1'b1, 1'b0, OP_R, F_RDY, "add_fetch");
    cyc(1'b1, 1'b0, OP_R, DEC,   "add_decode");
    cyc(1'b1, 1'b0, OP_R, EXR,   "add_exec");
    cyc(1'b1, 1'b0, OP_R, ALUWB, "add_wb");
    exp_ret++;

    // ADDI
    push(1'b0, 4);
    cyc(1'b1, 1'b0, OP_I, F_RDY, "addi_fetch");
    cyc(1'b1, 1'b0, OP_I, DEC,   "addi_decode");
    cyc(1'b1, 1'b0, OP_I, EXI,   "addi_exec");
    cyc(1'b1, 1'b0, OP_I, ALUWB, "addi_wb");
    exp_ret++;

    // LW, two wait cycles in MEM_READ; opcode changes after decode to prove latching
    push(1'b0, 7);
    cyc(1'b1, 1'b0, OP_LW, F_RDY, "lw_fetch");
    cyc(1'b1, 1'b0, OP_LW, DEC,   "lw_decode");
    cyc(1'b0, 1'b0, OP_SW, MADDR, "lw_addr");
    cyc(1'b0, 1'b0, OP_SW, MRD,   "lw_read_w0");
    cyc(1'b0, 1'b0, OP_SW, MRD,   "lw_read_w1");
    cyc(1'b1, 1'b0, OP_SW, MRD,   "lw_read_rdy");
    cyc(1'b0, 1'b0, OP_SW, MWB,   "lw_wb");
    exp_ret++;

    // SW with one FETCH wait cycle
    push(1'b0, 5);
    cyc(1'b0, 1'b0, OP_SW, F_WAIT,  "sw_fetch_w");
    cyc(1'b1, 1'b0, OP_SW, F_RDY,   "sw_fetch");
    cyc(1'b1, 1'b0, OP_SW, DEC,     "sw_decode");
    cyc(1'b1, 1'b0, OP_LW, MADDR,   "sw_addr");
    cyc(1'b1, 1'b0, OP_LW, MWR_RDY, "sw_write");
    exp_ret++;

    // BEQ taken / not taken
    push(1'b0, 3);
    cyc(1'b1, 1'b1, OP_B, F_RDY, "beq1_fetch");
    cyc(1'b1, 1'b1, OP_B, DEC,   "beq1_decode");
    cyc(1'b1, 1'b1, OP_B, BR_Z1, "beq1_branch");
    exp_ret++;
    push(1'b0, 3);
    cyc(1'b1, 1'b0, OP_B, F_RDY, "beq0_fetch");
    cyc(1'b1, 1'b0, OP_B, DEC,   "beq0_decode");
    cyc(1'b1, 1'b0, OP_B, BR_Z0, "beq0_branch");
    exp_ret++;

    // Unsupported opcode: illegal pulse, no retirement
    push(1'b1, 3);
    cyc(1'b1, 1'b0, OP_BAD, F_RDY, "ill_fetch");
    cyc(1'b1, 1'b0, OP_BAD, DEC,   "ill_decode");
    cyc(1'b1, 1'b0, OP_BAD, ILL,   "ill_state");

    // SW abandoned by reset while waiting in MEM_WRITE
    cyc(1'b1, 1'b0, OP_SW, F_RDY, "swr_fetch");
    cyc(1'b1, 1'b0, OP_SW, DEC,   "swr_decode");
    cyc(1'b1, 1'b0, OP_SW, MADDR, "swr_addr");
    cyc(1'b0, 1'b0, OP_SW, MWR_W, "swr_write_w");
    rst = 1'b1;
    exp_ret = 32'd0;
    cyc(1'b1, 1'b0, OP_SW, V_ZERO, "swr_reset");
    rst = 1'b0;

`ifdef MC_CTRL_PERF_EN
    force dut.instret_r = 32'hFFFF_FFFF;
    #1;
    release dut.instret_r;
    exp_ret = 32'hFFFF_FFFF;
`endif
    // SW retiring into the counter wrap when the counter is present
    push(1'b0, 4);
    cyc(1'b1, 1'b0, OP_SW, F_RDY,   "wrap_fetch");
    cyc(1'b1, 1'b0, OP_SW, DEC,     "wrap_decode");
    cyc(1'b1, 1'b0, OP_SW, MADDR,   "wrap_addr");
    cyc(1'b1, 1'b0, OP_SW, MWR_RDY, "wrap_write");
    exp_ret++;
    cyc(1'b1, 1'b0, OP_R, F_RDY, "post_fetch");

    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending events expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
